csr_ctrl: RTL

CSR_CTRL -- requirements
Module: csr_ctrl

---
 rtl/csr_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/csr_ctrl.sv
// CSR instruction sequencer: accepts a Zicsr request, reads the CSR file,
// performs the read-modify-write and returns the old value for rd.
module csr_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter bit          RO_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        op_i,
  input  logic [11:0]       addr_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic              rs1_is_x0_i,
  input  logic [4:0]        zimm_i,
  input  logic [4:0]        rd_addr_i,
  output logic [11:0]       csr_raddr_o,
  input  logic [DATA_W-1:0] csr_rdata_i,
  output logic              csr_we_o,
  output logic [11:0]       csr_waddr_o,
  output logic [DATA_W-1:0] csr_wdata_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [4:0]        resp_rd_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              illegal_o
);

  localparam int unsigned AW = 12;
  localparam int unsigned RW = 5;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state_q;
  logic [1:0]        op_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] opnd_q;
  logic [RW-1:0]     rd_q;
  logic              need_q;
  logic              ill_q;
  logic [DATA_W-1:0] old_q;

  logic              op_ok;
  logic              need_d;
  logic              ro_hit;
  logic [DATA_W-1:0] opnd_d;
  logic [DATA_W-1:0] wdata_d;

  // Request decode: op[1:0] selects RW/RS/RC, op[2] selects the immediate form
  always_comb begin
    op_ok  = (op_i[1:0] != 2'b00);
    opnd_d = op_i[2] ? DATA_W'(zimm_i) : rs1_data_i;
    need_d = (op_i[1:0] == 2'b01) || (op_i[2] ? (zimm_i != 5'd0) : !rs1_is_x0_i);
  end

  // New CSR value from the live read data, used on the READ->WRITE edge
  always_comb begin
    wdata_d = opnd_q;
    ro_hit  = RO_CHECK && (addr_q[11:10] == 2'b11);
    case (op_q)
      2'b10:   wdata_d = csr_rdata_i | opnd_q;
      2'b11:   wdata_d = csr_rdata_i & ~opnd_q;
      default: wdata_d = opnd_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      addr_q       <= '0;
      opnd_q       <= '0;
      rd_q         <= '0;
      need_q       <= 1'b0;
      ill_q        <= 1'b0;
      old_q        <= '0;
      req_ready_o  <= 1'b1;
      csr_raddr_o  <= '0;
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
      resp_valid_o <= 1'b0;
      resp_rd_o    <= '0;
      resp_data_o  <= '0;
      illegal_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            op_q        <= op_i[1:0];
            addr_q      <= addr_i;
            opnd_q      <= opnd_d;
            rd_q        <= rd_addr_i;
            need_q      <= need_d;
            if (op_ok) begin
              state_q     <= READ;
              csr_raddr_o <= addr_i;
            end else begin
              state_q      <= RESP;
              resp_valid_o <= 1'b1;
              resp_rd_o    <= rd_addr_i;
              resp_data_o  <= '0;
              illegal_o    <= 1'b1;
            end
          end
        end
        READ: begin
          state_q     <= WRITE;
          csr_raddr_o <= '0;
          old_q       <= csr_rdata_i;
          ill_q       <= need_q && ro_hit;
          if (need_q && !ro_hit) begin
            csr_we_o    <= 1'b1;
            csr_waddr_o <= addr_q;
            csr_wdata_o <= wdata_d;
          end
        end
        WRITE: begin
          state_q      <= RESP;
          csr_we_o     <= 1'b0;
          csr_waddr_o  <= '0;
          csr_wdata_o  <= '0;
          resp_valid_o <= 1'b1;
          resp_rd_o    <= rd_q;
          resp_data_o  <= old_q;
          illegal_o    <= ill_q;
        end
        RESP: begin
          if (resp_ready_i) begin
            state_q      <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rd_o    <= '0;
            resp_data_o  <= '0;
            illegal_o    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
